// File: rtl/dma_ac_pkg.sv
// rtl/dma_ac_pkg.sv - shared types and constants for the DMA access controller
// Purpose: FSM state encoding, hold counter width and default region map.
// Ports: none (package).
package dma_ac_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } state_t;

  localparam int CNT_W       = 8;
  localparam int MAX_REGIONS = 8;

  // Default map: region 0 = 6A00..6A1E (no access), region 1 = E000..EFFF (no writes).
  localparam logic [31:0] DEF_REGION_BASE  = {16'hE000, 16'h6A00};
  localparam logic [31:0] DEF_REGION_SIZE  = {16'h1000, 16'h001F};
  localparam logic [1:0]  DEF_WR_ONLY_MASK = 2'b10;

endpackage

// File: rtl/dma_ac_multi_if.sv
// rtl/dma_ac_multi_if.sv - DMA bus access signals seen by the access controller
// Purpose: bundles one DMA access (address, valid, write) per cycle.
// Ports: dma_addr[15:0], dma_en, dma_we; master drives, slave observes.
interface dma_ac_multi_if;

  logic [15:0] dma_addr;
  logic        dma_en;
  logic        dma_we;

  modport master (output dma_addr, output dma_en, output dma_we);
  modport slave  (input  dma_addr, input  dma_en, input  dma_we);

endinterface

// File: rtl/dma_region_match.sv
// rtl/dma_region_match.sv - single protected-region address check
// Purpose: flags a DMA access that falls inside [BASE, BASE+SIZE) and is of a
//          blocked kind; purely combinational.
// Ports: dma_addr, dma_en, dma_we in; viol out.
module dma_region_match #(
  parameter logic [15:0] BASE    = 16'h0000,
  parameter logic [15:0] SIZE    = 16'h0000,
  parameter bit          WR_ONLY = 1'b0
) (
  input  logic [15:0] dma_addr,
  input  logic        dma_en,
  input  logic        dma_we,
  output logic        viol
);

  logic [16:0] limit;
  logic        match;

  // 17-bit limit so a region ending at FFFF does not wrap to a tiny range.
  assign limit = {1'b0, BASE} + {1'b0, SIZE};
  assign match = (SIZE != 16'h0000)
              && ({1'b0, dma_addr} >= {1'b0, BASE})
              && ({1'b0, dma_addr} < limit);
  assign viol  = match && dma_en && (!WR_ONLY || dma_we);

endmodule

// File: rtl/dma_ac_multi.sv
// rtl/dma_ac_multi.sv - multi-region DMA access controller with CPU kill/reset
// Purpose: traps DMA accesses to protected regions, holds the CPU in reset for
//          at least HOLD_CYCLES cycles and until the PC reaches RESET_HANDLER.
// Ports: clk, rst (sync, active-high), pc[15:0], dma (slave modport),
//        reset (high in KILL), viol_region[NUM_REGIONS-1:0], viol_count[7:0].
module dma_ac_multi
  import dma_ac_pkg::*;
#(
  parameter int          NUM_REGIONS   = 2,
  parameter              REGION_BASE   = DEF_REGION_BASE,
  parameter              REGION_SIZE   = DEF_REGION_SIZE,
  parameter              WR_ONLY_MASK  = DEF_WR_ONLY_MASK,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          HOLD_CYCLES   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            pc,
  dma_ac_multi_if.slave          dma,
  output logic                   reset,
  output logic [NUM_REGIONS-1:0] viol_region,
  output logic [7:0]             viol_count
);

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

  if (NUM_REGIONS < 1 || NUM_REGIONS > MAX_REGIONS) begin : g_bad_num_regions
    $error("dma_ac_multi: NUM_REGIONS must be 1..8");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold_cycles
    $error("dma_ac_multi: HOLD_CYCLES must be 1..255");
  end
  if ($bits(REGION_BASE) != 16 * NUM_REGIONS) begin : g_bad_base_width
    $error("dma_ac_multi: REGION_BASE must be 16*NUM_REGIONS bits");
  end
  if ($bits(REGION_SIZE) != 16 * NUM_REGIONS) begin : g_bad_size_width
    $error("dma_ac_multi: REGION_SIZE must be 16*NUM_REGIONS bits");
  end
  if ($bits(WR_ONLY_MASK) != NUM_REGIONS) begin : g_bad_mask_width
    $error("dma_ac_multi: WR_ONLY_MASK must be NUM_REGIONS bits");
  end

  logic [NUM_REGIONS-1:0] region_viol;
  logic                   invalid;

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    dma_region_match #(
      .BASE    (REGION_BASE[16*i +: 16]),
      .SIZE    (REGION_SIZE[16*i +: 16]),
      .WR_ONLY (WR_ONLY_MASK[i])
    ) u_match (
      .dma_addr (dma.dma_addr),
      .dma_en   (dma.dma_en),
      .dma_we   (dma.dma_we),
      .viol     (region_viol[i])
    );
  end

  assign invalid = |region_viol;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0] region_d;
  logic [7:0]             count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_KILL;
      cnt_q       <= HOLD_INIT;
      viol_region <= '0;
      viol_count  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      viol_region <= region_d;
      viol_count  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = viol_region;
    count_d  = viol_count;
    case (state_q)
      ST_RUN: begin
        if (invalid) begin
          state_d  = ST_KILL;
          cnt_d    = HOLD_INIT;
          region_d = region_viol;
          count_d  = (viol_count == 8'hFF) ? 8'hFF : viol_count + 8'd1;
        end
      end
      ST_KILL: begin
        // Violations here only block the exit; the trap record is untouched.
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_q == '0 && pc == RESET_HANDLER && !invalid) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_KILL;
    endcase
  end

  assign reset = (state_q == ST_KILL);

endmodule

// File: tb/tb_dma_ac_multi.sv
// tb/tb_dma_ac_multi.sv - directed self-checking bench for dma_ac_multi
module tb_dma_ac_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc  = 16'h0000;
  logic        reset, reset2;
  logic [1:0]  viol_region, viol_region2;
  logic [7:0]  viol_count, viol_count2;
  int          errors = 0;
  int          checks = 0;

  dma_ac_multi_if dbus ();
  dma_ac_multi_if dbus2 ();

  always #5 clk = ~clk;

  dma_ac_multi dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .dma         (dbus.slave),
    .reset       (reset),
    .viol_region (viol_region),
    .viol_count  (viol_count)
  );

  // Two overlapping regions: 1000..10FF and 1080..117F, both fully blocked.
  dma_ac_multi #(
    .NUM_REGIONS  (2),
    .REGION_BASE  (32'h1080_1000),
    .REGION_SIZE  (32'h0100_0100),
    .WR_ONLY_MASK (2'b00)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .dma         (dbus2.slave),
    .reset       (reset2),
    .viol_region (viol_region2),
    .viol_count  (viol_count2)
  );

  task automatic drive(input logic en, input logic we, input logic [15:0] addr);
    dbus.dma_en   = en;
    dbus.dma_we   = we;
    dbus.dma_addr = addr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts negedges with reset high, starting at the current one.
  task automatic wait_exit(output int n);
    n = 0;
    while (reset === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    pc = 16'h0000;
    idle();
    do_rst();
    checks++; if (reset !== 1'b1) begin errors++; $display("FAIL rst_reset: got %b want 1", reset); end
    checks++; if (viol_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", viol_count); end
    checks++; if (viol_region !== 2'b00) begin errors++; $display("FAIL rst_region: got %b want 00", viol_region); end
    wait_exit(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL rst_hold_len: got %0d want 4", n); end
    checks++; if (reset !== 1'b0) begin errors++; $display("FAIL rst_exit: got %b want 0", reset); end
  endtask

  task automatic test_region0_read();
    int n;
    drive(1'b1, 1'b0, 16'h6A1F);
    @(negedge clk);
    checks++; if (reset !== 1'b0) begin errors++; $display("FAIL r0_upper_edge: got %b want 0", reset); end
    drive(1'b1, 1'b0, 16'h69FF);
    @(negedge clk);
    checks++; if (reset !== 1'b0) begin errors++; $display("FAIL r0_below: got %b want 0", reset); end
    drive(1'b1, 1'b0, 16'h6A1E);
    @(negedge clk);
    checks++; if (reset !== 1'b1) begin errors++; $display("FAIL r0_trap: got %b want 1", reset); end
    checks++; if (viol_region !== 2'b01) begin errors++; $display("FAIL r0_region: got %b want 01", viol_region); end
    checks++; if (viol_count !== 8'd1) begin errors++; $display("FAIL r0_count: got %0d want 1", viol_count); end
    idle();
    wait_exit(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL r0_hold_len: got %0d want 4", n); end
  endtask

  task automatic test_region1_wr_only();
    int n;
    drive(1'b1, 1'b0, 16'hE800);
    @(negedge clk);
    checks++; if (reset !== 1'b0) begin errors++; $display("FAIL r1_read: got %b want 0", reset); end
    drive(1'b1, 1'b1, 16'hF000);
    @(negedge clk);
    checks++; if (reset !== 1'b0) begin errors++; $display("FAIL r1_above: got %b want 0", reset); end
    drive(1'b1, 1'b1, 16'hE800);
    @(negedge clk);
    checks++; if (reset !== 1'b1) begin errors++; $display("FAIL r1_write: got %b want 1", reset); end
    checks++; if (viol_region !== 2'b10) begin errors++; $display("FAIL r1_region: got %b want 10", viol_region); end
    checks++; if (viol_count !== 8'd2) begin errors++; $display("FAIL r1_count: got %0d want 2", viol_count); end
    idle();
    wait_exit(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL r1_hold_len: got %0d want 4", n); end
    checks++; if (viol_region !== 2'b10) begin errors++; $display("FAIL r1_region_sticky: got %b want 10", viol_region); end
  endtask

  task automatic test_kill_violation();
    drive(1'b1, 1'b1, 16'hE000);
    @(negedge clk);
    checks++; if (reset !== 1'b1) begin errors++; $display("FAIL kv_trap: got %b want 1", reset); end
    idle();
    repeat (3) @(negedge clk);
    checks++; if (reset !== 1'b1) begin errors++; $display("FAIL kv_hold4: got %b want 1", reset); end
    drive(1'b1, 1'b1, 16'h6A00);
    @(negedge clk);
    checks++; if (reset !== 1'b1) begin errors++; $display("FAIL kv_blocked: got %b want 1", reset); end
    checks++; if (viol_count !== 8'd3) begin errors++; $display("FAIL kv_count: got %0d want 3", viol_count); end
    checks++; if (viol_region !== 2'b10) begin errors++; $display("FAIL kv_region: got %b want 10", viol_region); end
    idle();
    @(negedge clk);
    checks++; if (reset !== 1'b0) begin errors++; $display("FAIL kv_late_exit: got %b want 0", reset); end
  endtask

  task automatic test_pc_gate();
    pc = 16'h1234;
    drive(1'b1, 1'b0, 16'h6A00);
    @(negedge clk);
    idle();
    repeat (6) @(negedge clk);
    checks++; if (reset !== 1'b1) begin errors++; $display("FAIL pc_wrong_holds: got %b want 1", reset); end
    pc = 16'h0000;
    @(negedge clk);
    checks++; if (reset !== 1'b0) begin errors++; $display("FAIL pc_ok_exit: got %b want 0", reset); end
  endtask

  task automatic test_back_to_back();
    int n;
    drive(1'b1, 1'b1, 16'hEFFF);
    @(negedge clk);
    checks++; if (reset !== 1'b1) begin errors++; $display("FAIL b2b_trap: got %b want 1", reset); end
    checks++; if (viol_count !== 8'd5) begin errors++; $display("FAIL b2b_count: got %0d want 5", viol_count); end
    idle();
    wait_exit(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_hold_len: got %0d want 4", n); end
  endtask

  task automatic test_saturation();
    int n;
    do_rst();
    wait_exit(n);
    checks++; if (viol_count !== 8'd0) begin errors++; $display("FAIL sat_start: got %0d want 0", viol_count); end
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 1'b0, 16'h6A10);
      @(negedge clk);
      idle();
      wait_exit(n);
    end
    checks++; if (viol_count !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", viol_count); end
    drive(1'b1, 1'b0, 16'h6A10);
    @(negedge clk);
    checks++; if (reset !== 1'b1) begin errors++; $display("FAIL sat_256_trap: got %b want 1", reset); end
    checks++; if (viol_count !== 8'd255) begin errors++; $display("FAIL sat_256: got %0d want 255", viol_count); end
    idle();
    wait_exit(n);
  endtask

  task automatic test_rst_mid_hold();
    int n;
    drive(1'b1, 1'b1, 16'h6A00);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h6A00);
    @(negedge clk);
    rst = 1'b0;
    idle();
    checks++; if (viol_region !== 2'b00) begin errors++; $display("FAIL mr_region: got %b want 00", viol_region); end
    checks++; if (viol_count !== 8'd0) begin errors++; $display("FAIL mr_count: got %0d want 0", viol_count); end
    wait_exit(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL mr_hold_len: got %0d want 4", n); end
  endtask

  task automatic test_overlap();
    int n;
    dbus2.dma_en   = 1'b1;
    dbus2.dma_we   = 1'b0;
    dbus2.dma_addr = 16'h10A0;
    @(negedge clk);
    dbus2.dma_en = 1'b0;
    checks++; if (reset2 !== 1'b1) begin errors++; $display("FAIL ov_trap: got %b want 1", reset2); end
    checks++; if (viol_region2 !== 2'b11) begin errors++; $display("FAIL ov_region: got %b want 11", viol_region2); end
    checks++; if (viol_count2 !== 8'd1) begin errors++; $display("FAIL ov_count: got %0d want 1", viol_count2); end
    n = 0;
    while (reset2 === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL ov_hold_len: got %0d want 4", n); end
  endtask

  initial begin
    idle();
    dbus2.dma_en   = 1'b0;
    dbus2.dma_we   = 1'b0;
    dbus2.dma_addr = 16'h0000;
    @(negedge clk);
    test_reset();
    test_region0_read();
    test_region1_wr_only();
    test_kill_violation();
    test_pc_gate();
    test_back_to_back();
    test_saturation();
    test_rst_mid_hold();
    test_overlap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_ac_multi.md
DMA_AC_MULTI -- requirements
Module: dma_ac_multi

Interface
REQ-001 Parameter NUM_REGIONS, default 2, number of protected DMA regions (1..8).
REQ-002 Parameter REGION_BASE, default {16'hE000,16'h6A00}, packed 16-bit base per region, region 0 in LSBs.
REQ-003 Parameter REGION_SIZE, default {16'h1000,16'h001F}, packed 16-bit size per region; size 0 disables that region.
REQ-004 Parameter WR_ONLY_MASK, default 2'b10, bit i=1: region i blocks DMA writes only; bit i=0: blocks reads and writes.
REQ-005 Parameter RESET_HANDLER, default 16'h0000, PC value required to leave KILL.
REQ-006 Parameter HOLD_CYCLES, default 4, minimum KILL cycles before exit allowed (1..255).
REQ-007 clk  input  1  system clock; all logic on posedge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 pc  input  16  current CPU program counter.
REQ-010 dma_addr  input  16  DMA bus address.
REQ-011 dma_en  input  1  DMA access valid this cycle.
REQ-012 dma_we  input  1  DMA access is a write (1) or read (0); meaningful only with dma_en.
REQ-013 reset  output  1  CPU reset request, high while in KILL.
REQ-014 viol_region  output  NUM_REGIONS  sticky one-hot-or-more mask of regions hit by the last trapped violation.
REQ-015 viol_count  output  8  saturating count of RUN->KILL transitions.

Function
REQ-016 Region i SHALL match when dma_addr >= BASE_i and dma_addr < BASE_i+SIZE_i, sum computed 17-bit (no wrap), and SIZE_i != 0.
REQ-017 Region i SHALL flag a violation when it matches, dma_en=1, and (WR_ONLY_MASK[i]=0 or dma_we=1).
REQ-018 invalid SHALL be the OR of all region violation flags, combinational, same cycle.
REQ-019 States: RUN, KILL; reset SHALL equal (state==KILL), driven from the state register, no combinational path from inputs.
REQ-020 RUN->KILL on the edge where invalid=1; reset high the following cycle (1-cycle latency).
REQ-021 On RUN->KILL, hold counter SHALL load HOLD_CYCLES-1, viol_region SHALL load the per-region violation mask, viol_count SHALL increment, saturating at 255.
REQ-022 In KILL, hold counter SHALL decrement each cycle, saturating at 0.
REQ-023 KILL->RUN on the edge where hold counter==0, pc==RESET_HANDLER and invalid=0; reset low the following cycle.
REQ-024 Violation while in KILL SHALL block exit that cycle, SHALL NOT reload the counter, update viol_region, or increment viol_count.
REQ-025 pc==RESET_HANDLER with counter>0 SHALL NOT exit KILL; exit occurs the first later cycle meeting REQ-023.
REQ-026 Overlapping regions SHALL set every matching bit in viol_region.
REQ-027 viol_region SHALL hold its value across KILL->RUN until the next trapped violation or rst.

Reset
REQ-028 rst=1 at a posedge SHALL force state=KILL, hold counter=HOLD_CYCLES-1, viol_region=0, viol_count=0; reset=1 the next cycle.
REQ-029 rst SHALL take priority over all transitions, including mid-hold and simultaneous violation.

Structure
REQ-030 Package dma_ac_pkg SHALL hold the state encoding (RUN=0, KILL=1), default region constants and counter width.
REQ-031 Sub-module dma_region_match (one per region, generated) SHALL compute match and violation for one region, purely combinational.
REQ-032 Parameter legality (NUM_REGIONS, HOLD_CYCLES ranges, vector widths) SHALL be checked at elaboration.

Verification
REQ-033 After rst, pc=0000, no DMA -> reset high exactly 4 cycles, then low; viol_count=0.
REQ-034 In RUN, dma_en=1, dma_we=0, dma_addr=6A1E -> reset high next cycle, viol_region=2'b01, viol_count=1; dma_addr=6A1F -> no trap.
REQ-035 In RUN, read at E800 -> no trap; write at E800 -> trap, viol_region=2'b10.
REQ-036 In KILL, pc=0000 held, write to 6A00 at hold cycle 4 -> exit delayed one cycle, viol_count unchanged.
REQ-037 256 trap/recover sequences -> viol_count saturates at 255.
REQ-038 rst asserted mid-hold with simultaneous violation -> viol_region=0, viol_count=0, counter reloaded, reset stays high 4 more cycles.
